// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
//   arb_state_t    : arbiter FSM states
//   TAG_PREFIX     : upper nibble of the source-tag byte (used with SRC_TAG_EN)
//   onehot_to_idx  : converts a one-hot vector (up to 8 bits) to a binary index
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TAG    = 2'd1,
        STREAM = 2'd2
    } arb_state_t;

    localparam logic [3:0] TAG_PREFIX = 4'hA;

    // OR-ing the indices of the set bits is exact for a one-hot input
    // and returns 0 for an all-zero input.
    function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) begin
                idx = idx | 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream bus between the requesters, the arbiter and the uart.
//   req_data/req_valid/req_last : per-requester byte, valid and end-of-packet
//   req_ready                   : per-requester byte accepted
//   tx_data/tx_valid/tx_ready   : merged byte stream towards the uart
// Modports: master = arbiter side, slave = requesters + uart side.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ-1:0]            req_ready;
    logic [DATA_WIDTH-1:0]         tx_data;
    logic                          tx_valid;
    logic                          tx_ready;

    modport master (
        input  req_data, req_valid, req_last, tx_ready,
        output req_ready, tx_data, tx_valid
    );

    modport slave (
        output req_data, req_valid, req_last, tx_ready,
        input  req_ready, tx_data, tx_valid
    );
endinterface

// File: rtl/uart_tx_arbiter_rr_priority_picker.sv
// Combinational round-robin picker.
//   req     : request vector
//   ptr     : index with highest priority this round
//   grant   : one-hot pick, first set request at or after ptr (wrapping)
//   any_req : at least one request present
// Rotates the request vector down by ptr using a doubled copy, isolates the
// lowest set bit, then rotates the result back up the same way.
module rr_priority_picker #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic               any_req
);
    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   rot_req;
    logic [NUM_REQ-1:0]   rot_gnt;
    logic [2*NUM_REQ-1:0] gnt_dbl;

    assign req_dbl = {req, req} >> ptr;
    assign rot_req = req_dbl[NUM_REQ-1:0];
    assign rot_gnt = rot_req & (~rot_req + ONE);
    assign gnt_dbl = {{NUM_REQ{1'b0}}, rot_gnt} << ptr;
    assign grant   = gnt_dbl[NUM_REQ-1:0] | gnt_dbl[2*NUM_REQ-1:NUM_REQ];
    assign any_req = |req;
endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter sharing one UART transmit channel
// between NUM_REQ byte-stream requesters.
//   clk, rst : clock, synchronous active-high reset
//   bus      : uart_tx_arbiter_if.master (requester side and uart side)
//   grant    : one-hot current owner, zero when idle
//   busy     : channel owned
// Optional build macro SRC_TAG_EN: prefixes each grant with a tag byte
// {TAG_PREFIX, owner index} before the owner's data is streamed.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 64
) (
    input  logic               clk,
    input  logic               rst,
    uart_tx_arbiter_if.master  bus,
    output logic [NUM_REQ-1:0] grant,
    output logic               busy
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    arb_state_t         state_reg;
    logic [NUM_REQ-1:0] grant_reg;
    logic [PTR_W-1:0]   ptr_reg;
    logic [CNT_W-1:0]   cnt_reg;

    logic [NUM_REQ-1:0]    pick_grant;
    logic                  any_req;
    logic [7:0]            grant_ext;
    logic [PTR_W-1:0]      owner;
    logic [PTR_W-1:0]      ptr_next;
    logic                  owner_valid;
    logic                  owner_last;
    logic                  xfer;
    logic                  release_now;
    logic [DATA_WIDTH-1:0] req_bytes [NUM_REQ];

    rr_priority_picker #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_picker (
        .req     (bus.req_valid),
        .ptr     (ptr_reg),
        .grant   (pick_grant),
        .any_req (any_req)
    );

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign req_bytes[gi]     = bus.req_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign bus.req_ready[gi] = (state_reg == STREAM) && grant_reg[gi] && bus.tx_ready;
        end
    endgenerate

    always_comb begin
        grant_ext              = '0;
        grant_ext[NUM_REQ-1:0] = grant_reg;
    end

    assign owner       = PTR_W'(onehot_to_idx(grant_ext));
    assign ptr_next    = (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + PTR_W'(1);
    assign owner_valid = |(bus.req_valid & grant_reg);
    // req_last of non-owners is masked off here
    assign owner_last  = |(bus.req_last & grant_reg);
    assign xfer        = (state_reg == STREAM) && owner_valid && bus.tx_ready;
    assign release_now = xfer && (owner_last || (cnt_reg == CNT_LAST));

    assign grant = grant_reg;
    assign busy  = (state_reg != IDLE);

    // Data path is a pass-through of the owner while streaming; an owner that
    // drops valid mid-packet keeps the grant with tx_valid low.
    always_comb begin
        bus.tx_valid = 1'b0;
        bus.tx_data  = '0;
        case (state_reg)
            STREAM: begin
                bus.tx_valid = owner_valid;
                bus.tx_data  = req_bytes[owner];
            end
`ifdef SRC_TAG_EN
            TAG: begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = DATA_WIDTH'({TAG_PREFIX, 4'(owner)});
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            grant_reg <= '0;
            ptr_reg   <= '0;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (any_req) begin
                        grant_reg <= pick_grant;
`ifdef SRC_TAG_EN
                        state_reg <= TAG;
`else
                        state_reg <= STREAM;
`endif
                    end
                end
`ifdef SRC_TAG_EN
                TAG: begin
                    // The tag byte is not counted towards MAX_BURST.
                    if (bus.tx_ready) begin
                        state_reg <= STREAM;
                    end
                end
`endif
                STREAM: begin
                    if (release_now) begin
                        state_reg <= IDLE;
                        grant_reg <= '0;
                        cnt_reg   <= '0;
                        ptr_reg   <= ptr_next;
                    end else if (xfer) begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    grant_reg <= '0;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end
endmodule
